// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared register-file widths, write-enable constants and arbiter state type.
package wb_arbiter_pkg;
    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam int NREG = 1 << REG_AW;
    localparam logic [REG_AW-1:0] ZERO_REG = '0;
    localparam logic WE_ON = 1'b1;
    localparam logic WE_OFF = 1'b0;
    typedef enum logic {NORMAL, FORCE} arb_state_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: multi-cycle write queue with a per-entry valid/address view for pending-register tracking.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [REG_AW-1:0]             push_addr,
    input  logic [REG_DW-1:0]             push_data,
    output logic [REG_AW-1:0]             head_addr,
    output logic [REG_DW-1:0]             head_data,
    output logic                          full,
    output logic                          empty,
    output logic [DEPTH-1:0]              valid,
    output logic [DEPTH-1:0][REG_AW-1:0]  addr
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic [REG_DW-1:0] data [DEPTH];
    logic do_push, do_pop;
    assign full = count == (PW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign head_addr = addr[rd_ptr];
    assign head_data = data[rd_ptr];
    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (do_push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr[wr_ptr] <= push_addr;
            data[wr_ptr] <= push_data;
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-port arbiter between pipeline write-back and queued multi-cycle results.
// Define WB_ARB_BYPASS_EN to let an mc write go straight to the port when nothing else contends.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [REG_AW-1:0] pipe_waddr,
    input  logic [REG_DW-1:0] pipe_wdata,
    input  logic              mc_valid,
    output logic              mc_ready,
    input  logic [REG_AW-1:0] mc_waddr,
    input  logic [REG_DW-1:0] mc_wdata,
    output logic              we,
    output logic [REG_AW-1:0] waddr,
    output logic [REG_DW-1:0] wdata,
    output logic              stall_req,
    output logic [NREG-1:0]   pend_mask
);
    arb_state_t state, state_next;
    logic [4:0] starve_cnt, starve_next;
    logic pipe_req, pipe_grant, mc_live, push, pop, bypass, full, empty;
    logic [REG_AW-1:0] head_addr;
    logic [REG_DW-1:0] head_data;
    logic [FIFO_DEPTH-1:0] valid;
    logic [FIFO_DEPTH-1:0][REG_AW-1:0] addr;
    assign pipe_req = pipe_we && pipe_waddr != ZERO_REG;
    assign mc_ready = !full && !rst;
    assign mc_live = mc_valid && mc_ready && mc_waddr != ZERO_REG;
`ifdef WB_ARB_BYPASS_EN
    assign bypass = mc_live && empty && !pipe_req && state == NORMAL;
`else
    assign bypass = 1'b0;
`endif
    assign push = mc_live && !bypass;
    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop),
        .push_addr(mc_waddr), .push_data(mc_wdata),
        .head_addr(head_addr), .head_data(head_data),
        .full(full), .empty(empty), .valid(valid), .addr(addr)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NORMAL;
            starve_cnt <= '0;
        end else begin
            state <= state_next;
            starve_cnt <= starve_next;
        end
    end
    // FORCE lasts one cycle: it always pops the starved head and hands back to NORMAL
    always_comb begin
        pipe_grant = !rst && state == NORMAL && pipe_req;
        pop = !rst && !empty && (state == FORCE || !pipe_req);
        we = (pipe_grant || pop || bypass) ? WE_ON : WE_OFF;
        waddr = pipe_grant ? pipe_waddr : pop ? head_addr : bypass ? mc_waddr : ZERO_REG;
        wdata = pipe_grant ? pipe_wdata : pop ? head_data : bypass ? mc_wdata : '0;
        stall_req = !rst && state == FORCE;
        starve_next = (state == FORCE || empty || pop) ? '0 : starve_cnt + 5'd1;
        state_next = (state == NORMAL && !empty && !pop && starve_cnt >= 5'(STARVE_LIMIT)) ? FORCE : NORMAL;
    end
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) pend_mask |= valid[i] ? NREG'(1) << addr[i] : '0;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table, multi-cycle corner sequences and a randomized run against a queue model.
module tb_wb_arbiter;
    localparam int SL = 4;
    localparam int FD = 2;
    logic clk = 0, rst = 1, pipe_we = 0, mc_valid = 0;
    logic [4:0] pipe_waddr = 0, mc_waddr = 0;
    logic [31:0] pipe_wdata = 0, mc_wdata = 0;
    logic mc_ready, we, stall_req;
    logic [4:0] waddr;
    logic [31:0] wdata, pend_mask;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.STARVE_LIMIT(SL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata),
        .we(we), .waddr(waddr), .wdata(wdata), .stall_req(stall_req), .pend_mask(pend_mask)
    );

    typedef struct {
        logic r, pwe; logic [4:0] pa; logic [31:0] pd;
        logic mv; logic [4:0] ma; logic [31:0] md;
        logic ewe; logic [4:0] ewa; logic [31:0] ewd; logic est, erdy; logic [31:0] epend;
    } vec_t;
    vec_t tbl[$];

    typedef struct {logic [4:0] a; logic [31:0] d;} ent_t;
    ent_t q[$];
    bit m_force;
    int m_wait;
    bit popd, byp, acc, had, erdy, est, ewe;
    logic [4:0] ea;
    logic [31:0] ed, ep;
    int pi, got;
    int fa[11] = '{1, 2, 3, 4, 5, 6, 7, 7, 8, 9, 10};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int r, pwe, pa, input logic [31:0] pd, input int mv, ma,
                                input logic [31:0] md, input int ewe_i, ewa, input logic [31:0] ewd,
                                input int est_i, erdy_i, input logic [31:0] epend);
        vec_t v;
        v.r = r[0]; v.pwe = pwe[0]; v.pa = pa[4:0]; v.pd = pd;
        v.mv = mv[0]; v.ma = ma[4:0]; v.md = md;
        v.ewe = ewe_i[0]; v.ewa = ewa[4:0]; v.ewd = ewd;
        v.est = est_i[0]; v.erdy = erdy_i[0]; v.epend = epend;
        return v;
    endfunction

    task automatic idle_inputs();
        pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
        mc_valid = 0; mc_waddr = 0; mc_wdata = 0;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        // fields: rst pwe pa pd mv ma md | we waddr wdata stall ready pend
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5, 32'hA5A5A5A5, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'hA5A5A5A5, 0, 1, 32'h20));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 10, 32'hA0, 1, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 2, 2, 1, 11, 32'hB0, 1, 2, 2, 0, 1, 32'h400));
        tbl.push_back(mk(0, 1, 3, 3, 1, 12, 32'hC0, 1, 3, 3, 0, 0, 32'hC00));
        tbl.push_back(mk(0, 0, 0, 0, 1, 12, 32'hC0, 1, 10, 32'hA0, 0, 0, 32'hC00));
        tbl.push_back(mk(0, 0, 0, 0, 1, 12, 32'hC0, 1, 11, 32'hB0, 0, 1, 32'h800));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 12, 32'hC0, 0, 1, 32'h1000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
`ifndef WB_ARB_BYPASS_EN
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            rst = tbl[i].r; pipe_we = tbl[i].pwe; pipe_waddr = tbl[i].pa; pipe_wdata = tbl[i].pd;
            mc_valid = tbl[i].mv; mc_waddr = tbl[i].ma; mc_wdata = tbl[i].md;
            @(negedge clk);
            chk($sformatf("vec%0d_we", i), we, tbl[i].ewe);
            chk($sformatf("vec%0d_waddr", i), waddr, tbl[i].ewa);
            chk($sformatf("vec%0d_wdata", i), wdata, tbl[i].ewd);
            chk($sformatf("vec%0d_stall", i), stall_req, tbl[i].est);
            chk($sformatf("vec%0d_ready", i), mc_ready, tbl[i].erdy);
            chk($sformatf("vec%0d_pend", i), pend_mask, tbl[i].epend);
        end
`endif

        // starved mc write forced out while the pipeline streams r1..r10
        reset_dut();
        pi = 1;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            pipe_we = 1; pipe_waddr = pi[4:0]; pipe_wdata = 32'h100 + pi;
            mc_valid = (c == 0); mc_waddr = 7; mc_wdata = 7;
            @(negedge clk);
            chk($sformatf("force%0d_stall", c), stall_req, c == 6);
            chk($sformatf("force%0d_we", c), we, 1);
            chk($sformatf("force%0d_waddr", c), waddr, fa[c]);
            chk($sformatf("force%0d_wdata", c), wdata, c == 6 ? 32'h7 : 32'h100 + fa[c]);
            if (!stall_req) pi++;
        end

        // reset while in FORCE with two queued entries
        reset_dut();
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            @(posedge clk); #1;
            pipe_we = 1; pipe_waddr = 1; pipe_wdata = c;
            mc_valid = (c < 2); mc_waddr = (c == 0) ? 5'd20 : 5'd21; mc_wdata = c;
            @(negedge clk);
            if (stall_req) got = 1;
        end
        chk("rst_force_seen", got, 1);
        chk("rst_pend_pre", pend_mask, 32'h0030_0000);
        rst = 1; mc_valid = 0;
        #1;
        chk("rst_we", we, 0);
        chk("rst_ready", mc_ready, 0);
        @(posedge clk); #1;
        rst = 0;
        idle_inputs();
        @(negedge clk);
        chk("post_rst_stall", stall_req, 0);
        chk("post_rst_pend", pend_mask, 0);
        chk("post_rst_ready", mc_ready, 1);
        chk("post_rst_we", we, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_we", c), we, 0);
        end

`ifdef WB_ARB_BYPASS_EN
        reset_dut();
        @(posedge clk); #1;
        mc_valid = 1; mc_waddr = 3; mc_wdata = 32'h33;
        @(negedge clk);
        chk("byp_we", we, 1);
        chk("byp_waddr", waddr, 3);
        chk("byp_wdata", wdata, 32'h33);
        chk("byp_pend", pend_mask, 0);
        @(posedge clk); #1;
        mc_valid = 0;
        @(negedge clk);
        chk("byp_after_we", we, 0);
        chk("byp_after_pend", pend_mask, 0);
`endif

        // randomized traffic against a queue-level model
        reset_dut();
        q.delete(); m_force = 0; m_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(63) == 0);
            if (!m_force) begin
                pipe_we = ($urandom_range(3) != 0);
                pipe_waddr = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                pipe_wdata = $urandom;
            end
            mc_valid = $urandom_range(1);
            mc_waddr = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            mc_wdata = $urandom;
            @(negedge clk);
            erdy = !rst && q.size() < FD;
            est = !rst && m_force;
            ep = 0;
            foreach (q[k]) ep[q[k].a] = 1'b1;
            ewe = 0; ea = 0; ed = 0; popd = 0; byp = 0;
            if (!rst) begin
                if (!m_force && pipe_we && pipe_waddr != 0) begin
                    ewe = 1; ea = pipe_waddr; ed = pipe_wdata;
                end else if (q.size() > 0) begin
                    ewe = 1; ea = q[0].a; ed = q[0].d; popd = 1;
                end
`ifdef WB_ARB_BYPASS_EN
                if (!ewe && mc_valid && erdy && mc_waddr != 0) begin
                    ewe = 1; ea = mc_waddr; ed = mc_wdata; byp = 1;
                end
`endif
            end
            chk("rnd_we", we, ewe);
            chk("rnd_waddr", waddr, ea);
            chk("rnd_wdata", wdata, ed);
            chk("rnd_stall", stall_req, est);
            chk("rnd_ready", mc_ready, erdy);
            chk("rnd_pend", pend_mask, ep);
            if (rst) begin
                q.delete(); m_force = 0; m_wait = 0;
            end else begin
                had = q.size() > 0;
                acc = mc_valid && erdy && mc_waddr != 0 && !byp;
                if (popd) void'(q.pop_front());
                if (acc) q.push_back('{mc_waddr, mc_wdata});
                m_wait = (!m_force && had && !popd) ? m_wait + 1 : 0;
                m_force = (m_wait == SL + 1);
            end
        end
        rst = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive cycles a queued multi-cycle write waits before it is forced onto the port; legal range 1..15.
REQ-002 Parameter FIFO_DEPTH, default 2: number of entries in the multi-cycle write queue; legal values 2 or 4.
REQ-003 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port pipe_we, input, 1: pipeline write-back request.
REQ-006 Port pipe_waddr, input, 5: pipeline destination register.
REQ-007 Port pipe_wdata, input, 32: pipeline write data.
REQ-008 Port mc_valid, input, 1: multi-cycle unit (divider/load) result valid.
REQ-009 Port mc_ready, output, 1: queue can accept an mc write this cycle.
REQ-010 Port mc_waddr, input, 5: mc destination register.
REQ-011 Port mc_wdata, input, 32: mc write data.
REQ-012 Port we, output, 1: write enable to the register file write port.
REQ-013 Port waddr, output, 5: write address to the register file.
REQ-014 Port wdata, output, 32: write data to the register file.
REQ-015 Port stall_req, output, 1: pipeline must hold its write-back stage this cycle.
REQ-016 Port pend_mask, output, 32: bit i set while a queued mc write targets register i.

Function
REQ-017 The mc handshake SHALL complete when mc_valid and mc_ready are both high on a rising edge; the entry is pushed at the queue tail.
REQ-018 mc_ready SHALL be 1 when the queue is not full; it SHALL depend only on registered occupancy, so a same-cycle pop does not raise it.
REQ-019 Writes to register 0 SHALL be discarded: pipe_we with pipe_waddr=0 is not a request, and an mc write to 0 is accepted but never queued.
REQ-020 FSM states: NORMAL and FORCE.
REQ-021 In NORMAL, a pipe request SHALL win; otherwise a non-empty queue SHALL grant its head, pop it, and drive we/waddr/wdata combinationally in the same cycle.
REQ-022 starve_cnt SHALL increment each NORMAL cycle the queue is non-empty and its head is not granted, and clear on any head grant or when the queue is empty.
REQ-023 When starve_cnt reaches STARVE_LIMIT, the FSM SHALL go to FORCE on the next edge.
REQ-024 In FORCE, the arbiter SHALL hold stall_req at 1 (decoded from the state register), grant and pop the head, ignore pipe_*, clear starve_cnt, and return to NORMAL on the next edge.
REQ-025 The pipeline keeps pipe_* stable while stall_req is 1, so the held write is serviced in the following cycle.
REQ-026 Queue order SHALL be strict FIFO; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 pend_mask SHALL be the OR of the one-hot addresses of all valid entries, updated on the edge after each push or pop.
REQ-028 Decode uses pend_mask to enforce ordering between the pipe and mc sources.
REQ-029 On the same edge as a pop, the queue SHALL accept a push when it was not full before that edge.
REQ-030 When no write is granted, we SHALL be 0 and waddr/wdata SHALL be 0.

Reset
REQ-031 While rst is high at an edge, the arbiter SHALL empty the queue, clear starve_cnt, and set the state to NORMAL.
REQ-032 After that edge, we=0, stall_req=0, pend_mask=0, and mc_ready=1 once rst is low.
REQ-033 While rst is high, we=0 and mc_ready=0.
REQ-034 Queued entries SHALL be lost on reset mid-operation.

Configuration
REQ-035 With WB_ARB_BYPASS_EN defined, an mc handshake SHALL write directly to the port in the same cycle, without queuing, when the queue is empty, no pipe request is present, and the address is nonzero.
REQ-036 Without WB_ARB_BYPASS_EN, every mc write SHALL pass through the queue, giving a minimum latency of one cycle.

Structure
REQ-037 Register address/data widths, the zero-register address, and the write-enable constants SHALL come from the shared defines package.
REQ-038 STARVE_LIMIT and FIFO_DEPTH stay local to the module.
REQ-039 The queue SHALL be a single sub-module, wb_fifo, with push/pop/full/empty ports and a per-entry valid and address view for pend_mask.

Verification
REQ-040 mc write r5=0xA5A5A5A5 with the pipe idle, bypass off -> we=1, waddr=5 one cycle after the handshake; pend_mask bit 5 is set for one cycle.
REQ-041 pipe_we held for 10 cycles (r1..r10), mc write r7=0x7 queued, STARVE_LIMIT=4 -> FORCE entered and stall_req=1 exactly one cycle, r7 written in that cycle, the held pipe write completes next cycle.
REQ-042 Three back-to-back mc writes with the pipe busy, FIFO_DEPTH=2 -> mc_ready=0 after two accepts; the third is accepted on the edge after the first pop; write order is preserved.
REQ-043 pipe_we=1 to r0, then mc write to r0 -> we stays 0 and pend_mask stays 0.
REQ-044 rst asserted with two queued entries and the FSM in FORCE -> next cycle queue empty, NORMAL, stall_req=0, and no stale writes afterward.
REQ-045 Bypass on, mc write r3=0x33 with the queue empty and the pipe idle -> we=1, waddr=3 in the handshake cycle; pend_mask stays 0.
